// File: rtl/dino_pkg.sv
// Shared encodings for the dino Q-learning slice: game states, verdict codes,
// jump FSM states and the default cactus pass line.
package dino_pkg;

    localparam logic [1:0] ST_QLEARN = 2'b10;

    localparam logic [9:0] PASS_X_DEFAULT = 10'd519;

    typedef enum logic [1:0] {
        Q_NONE     = 2'b00,
        Q_GOOD     = 2'b01,
        Q_BAD_STAY = 2'b10,
        Q_BAD_JUMP = 2'b11
    } qstate_e;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        AIR    = 2'd1,
        COOL   = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/jump_reward_if.sv
// Bot/physics side signals of jump_reward. The jump_count/hit_count statistics
// only exist when JUMP_REWARD_STATS_EN is defined.
interface jump_reward_if;

    logic       new_frame;
    logic [1:0] state;
    logic       prediction;
    logic [9:0] position;
    logic       on_ground;
    logic       collision;
    logic       jump_req;
    logic       success_jump;
    logic [1:0] Qstate;
    logic       busy;
`ifdef JUMP_REWARD_STATS_EN
    logic [15:0] jump_count;
    logic [15:0] hit_count;
`endif

    modport master (
        output new_frame, state, prediction, position, on_ground, collision,
        input  jump_req, success_jump, Qstate, busy
`ifdef JUMP_REWARD_STATS_EN
        , input jump_count, hit_count
`endif
    );

    modport slave (
        input  new_frame, state, prediction, position, on_ground, collision,
        output jump_req, success_jump, Qstate, busy
`ifdef JUMP_REWARD_STATS_EN
        , output jump_count, hit_count
`endif
    );

endinterface

// File: rtl/jump_reward_sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping; clear beats increment.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/jump_reward.sv
// Jump launcher and reward judge for the Q-learning dino bot.
// Optional JUMP_REWARD_STATS_EN adds saturating jump/hit statistics.
module jump_reward
    import dino_pkg::*;
#(
    parameter logic [9:0] PASS_X   = PASS_X_DEFAULT,
    parameter logic [5:0] AIR_MAX  = 6'd63,
    parameter logic [2:0] COOLDOWN = 3'd4
) (
    input logic          clk,
    input logic          reset,
    jump_reward_if.slave bus
);

    localparam int unsigned FRAME_W = $bits(AIR_MAX);
    localparam int unsigned COOL_W  = $bits(COOLDOWN);

    fsm_state_e         fsm_q, fsm_d;
    logic               jump_q, jump_d;
    qstate_e            q_q, q_d;
    logic               qlearn;
    logic [FRAME_W-1:0] frame_cnt;
    logic [COOL_W-1:0]  cool_cnt;

    assign qlearn = (bus.state == ST_QLEARN);

    always_comb begin
        fsm_d  = fsm_q;
        jump_d = 1'b0;
        q_d    = Q_NONE;
        if (!qlearn) begin
            fsm_d = GROUND;
        end else begin
            unique case (fsm_q)
                GROUND: begin
                    if (bus.collision) begin
                        q_d   = Q_BAD_STAY;
                        fsm_d = COOL;
                    end else if (bus.new_frame && bus.prediction && bus.on_ground) begin
                        jump_d = 1'b1;
                        fsm_d  = AIR;
                    end
                end
                AIR: begin
                    // Collision outranks both timeout and landing.
                    if (bus.collision) begin
                        q_d   = Q_BAD_JUMP;
                        fsm_d = COOL;
                    end else if (frame_cnt == AIR_MAX) begin
                        fsm_d = GROUND;
                    end else if (bus.new_frame && bus.on_ground && (frame_cnt != '0)) begin
                        if (bus.position >= PASS_X) begin
                            q_d   = Q_GOOD;
                            fsm_d = COOL;
                        end else begin
                            fsm_d = GROUND;
                        end
                    end
                end
                COOL: begin
                    if (cool_cnt == COOLDOWN) fsm_d = GROUND;
                end
                default: fsm_d = GROUND;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q  <= GROUND;
            jump_q <= 1'b0;
            q_q    <= Q_NONE;
        end else begin
            fsm_q  <= fsm_d;
            jump_q <= jump_d;
            q_q    <= q_d;
        end
    end

    // Counters sit at zero outside their own state, so entry always starts from 0.
    sat_counter #(
        .WIDTH (FRAME_W)
    ) u_frame_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (!qlearn || (fsm_q != AIR)),
        .inc   (bus.new_frame),
        .count (frame_cnt)
    );

    sat_counter #(
        .WIDTH (COOL_W)
    ) u_cool_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (!qlearn || (fsm_q != COOL)),
        .inc   (bus.new_frame),
        .count (cool_cnt)
    );

`ifdef JUMP_REWARD_STATS_EN
    logic hit;

    assign hit = (q_d == Q_BAD_STAY) || (q_d == Q_BAD_JUMP);

    sat_counter #(
        .WIDTH (16)
    ) u_jump_stat (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (jump_d),
        .count (bus.jump_count)
    );

    sat_counter #(
        .WIDTH (16)
    ) u_hit_stat (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (hit),
        .count (bus.hit_count)
    );
`endif

    assign bus.jump_req     = jump_q;
    assign bus.success_jump = jump_q;
    assign bus.Qstate       = q_q;
    assign bus.busy         = (fsm_q != GROUND);

endmodule

// File: doc/jump_reward.md
JUMP_REWARD -- requirements
Module: jump_reward

Interface
REQ-001 Parameter PASS_X, default 10'd519; the cactus counts as passed when position >= PASS_X.
REQ-002 Parameter AIR_MAX, default 6'd63; the maximum number of frames spent in AIR before timeout.
REQ-003 Parameter COOLDOWN, default 3'd4; the number of frames after a verdict during which no jump is allowed.
REQ-004 The block SHALL have these ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- new_frame, input, 1: one-cycle frame strobe.
- state, input, 2: game state; 2'b10 = Q-learning.
- prediction, input, 1: jump request from the bot.
- position, input, 10: closest-cactus position, same coordinate as the bot's input.
- on_ground, input, 1: dino physics reports the dino is grounded.
- collision, input, 1: level signal, dino overlaps a cactus.
- jump_req, output, 1: one-cycle launch pulse to dino physics.
- success_jump, output, 1: one-cycle pulse, coincident with jump_req, that tells the bot to latch the distance.
- Qstate, output, 2: one-cycle verdict code for the bot.
- busy, output, 1: high in every state except GROUND.

Function
REQ-005 The FSM states SHALL be GROUND, AIR, COOL; only transitions listed here are legal.
REQ-006 GROUND->AIR SHALL occur on a new_frame cycle where state==2'b10, prediction==1, on_ground==1 and collision==0; jump_req and success_jump SHALL be high in exactly that cycle (registered, visible the next clk).
REQ-007 On entering AIR, the frame counter SHALL clear; it SHALL increment on each new_frame while in AIR.
REQ-008 In AIR, collision==1 SHALL emit Qstate=2'b11 for one cycle and go to COOL.
REQ-009 In AIR, if on_ground==1 on a new_frame after at least 1 AIR frame, with position>=PASS_X and no collision, the block SHALL emit Qstate=2'b01 for one cycle and go to COOL.
REQ-010 In AIR, landing with position<PASS_X SHALL emit no verdict (Qstate=0) and SHALL return to GROUND.
REQ-011 When the AIR frame count reaches AIR_MAX, the block SHALL emit Qstate=0 and go to GROUND.
REQ-012 In GROUND, collision==1 while state==2'b10 SHALL emit Qstate=2'b10 for one cycle and go to COOL.
REQ-013 COOL SHALL count COOLDOWN new_frame strobes and then return to GROUND; jump requests SHALL be ignored during COOL.
REQ-014 If collision and landing occur in the same cycle, collision SHALL win and give Qstate=2'b11.
REQ-015 If state!=2'b10 in any cycle, the block SHALL abort to GROUND, clear the counters and emit nothing.
REQ-016 Qstate SHALL be nonzero for exactly one clk per verdict, and at most one verdict SHALL be given per jump.
REQ-017 The counters SHALL saturate and never wrap; counter widths SHALL be fixed by the parameter widths.

Reset
REQ-018 Reset SHALL force the FSM to GROUND and set counters to 0, jump_req=0, success_jump=0, Qstate=2'b00 and busy=0, with priority over all inputs, including mid-AIR.

Configuration
REQ-019 With the macro JUMP_REWARD_STATS_EN defined, the block SHALL add outputs jump_count[15:0] and hit_count[15:0]:
- jump_count increments on each jump_req.
- hit_count increments on each Qstate=2'b11 or 2'b10.
- Both saturate at 16'hFFFF and reset to 0.
REQ-020 Without JUMP_REWARD_STATS_EN, those ports and registers SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-021 The shared package dino_pkg SHALL hold:
- Game state encodings: ST_QLEARN = 2'b10.
- Qstate codes: Q_NONE, Q_GOOD, Q_BAD_STAY, Q_BAD_JUMP.
- The FSM state enum.
- The PASS_X default.
REQ-022 The block SHALL use one sub-module, sat_counter (parameterised width, clear, increment enable, saturation), for the frame, cooldown and stats counters.

Verification
REQ-023 Scenario clean jump: state=2, prediction=1, on_ground=1 at new_frame; then on_ground=0 for 20 frames; then position=530, on_ground=1 -> one jump_req/success_jump pulse, then Qstate=01 for 1 clk, busy high until 4 frames later.
REQ-024 Scenario hit in air: after launch, collision=1 at frame 5 -> Qstate=11 for 1 clk, then COOL; prediction=1 during COOL gives no jump_req.
REQ-025 Scenario stay and hit: prediction=0 with collision=1 in GROUND -> Qstate=10 once; a collision held for 10 clks still gives exactly one verdict.
REQ-026 Scenario timeout and abort:
- on_ground held 0 for 63 frames -> Qstate stays 00, FSM returns to GROUND.
- Separately, state set to 2'b01 mid-AIR -> immediate GROUND with no verdict.
REQ-027 Scenario reset and simultaneity:
- collision and landing in the same cycle -> Qstate=11.
- reset asserted mid-AIR -> all outputs 0 next clk.
- With JUMP_REWARD_STATS_EN, 3 jumps and 1 hit -> jump_count=3, hit_count=1.
